// File: rtl/mont_arbiter.sv
// Round-robin arbiter/sequencer sharing one Montgomery multiplier between two requesters.
// Optional watchdog in WAIT enabled by defining MONT_ARB_TIMEOUT_EN.
module mont_arbiter #(
    parameter int WIDTH          = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] m0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] m1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             mult_resetn,
    output logic             mult_start,
    output logic [WIDTH-1:0] mult_a,
    output logic [WIDTH-1:0] mult_b,
    output logic [WIDTH-1:0] mult_m,
    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_done
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             win;

`ifdef MONT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        a_d          = a_q;
        b_d          = b_q;
        m_d          = m_q;
        result_d     = result_q;
        win          = 1'b0;
`ifdef MONT_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins.
                    win     = (req0 && req1) ? ~last_owner_q : req1;
                    owner_d = win;
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    m_d     = win ? m1 : m0;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef MONT_ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
            end
            WAIT: begin
                if (mult_done) begin
                    result_d     = mult_result;
                    last_owner_d = owner_q;
                    state_d      = RESP;
                end
`ifdef MONT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d     = '0;
                    err_d        = 1'b1;
                    last_owner_d = owner_q;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            m_q          <= '0;
            result_q     <= '0;
`ifdef MONT_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            m_q          <= m_d;
            result_q     <= result_d;
`ifdef MONT_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    // All handshake outputs are decoded from registered state only.
    assign ack0        = (state_q == START) && !owner_q;
    assign ack1        = (state_q == START) &&  owner_q;
    assign done0       = (state_q == RESP)  && !owner_q;
    assign done1       = (state_q == RESP)  &&  owner_q;
    assign mult_start  = (state_q == START);
    assign mult_resetn = (state_q == START) || (state_q == WAIT);
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign mult_m      = m_q;
    assign result      = result_q;
`ifdef MONT_ARB_TIMEOUT_EN
    assign err         = (state_q == RESP) && err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: doc/mont_arbiter.md
# mont_arbiter

Round-robin arbiter and sequencer that shares one `montgomery` multiplier instance between two requesters, e.g. two exponentiation ladders or a ladder and a pre-computation unit. It accepts a request, latches that requester's operands, and drives the multiplier's reset and start. It waits for the multiplier's done, captures the product and returns it to the owner with a one-cycle done pulse. It sits between the requesters and the multiplier; requesters never drive the multiplier directly.

## Interface

Parameters:
- `WIDTH`, default 1024: operand and result width in bits.
- `TIMEOUT_CYCLES`, default 4096: watchdog limit in WAIT. Used only with `MONT_ARB_TIMEOUT_EN`.

Ports:
- Clocking and reset:
  - `clk` in 1: single clock; all state changes on the rising edge.
  - `reset` in 1: synchronous, active-high reset.
- Requester 0:
  - `req0` in 1: requester 0 wants one multiplication.
  - `a0`, `b0`, `m0` in WIDTH each: operands; stable while `req0`=1 and `ack0`=0.
- Requester 1:
  - `req1`, `a1`, `b1`, `m1`: same as requester 0.
- Requester handshake:
  - `ack0`, `ack1` out 1: one-cycle pulse; operands captured, requester may drop its request.
  - `done0`, `done1` out 1: one-cycle pulse; `result` is valid for that owner.
  - `err` out 1: high with a done pulse when the operation timed out.
  - `result` out WIDTH: last captured product; held until the next capture.
- Multiplier side:
  - `mult_resetn` out 1: multiplier active-low reset.
  - `mult_start` out 1: multiplier start.
  - `mult_a`, `mult_b`, `mult_m` out WIDTH: latched operands.
  - `mult_result` in WIDTH, `mult_done` in 1: from the multiplier.

## Operation

FSM states: IDLE, START, WAIT, RESP.
- **IDLE**:
  - `mult_resetn`=0, which holds the multiplier in reset.
  - If either request is high on a clock edge, the arbiter picks a winner. On that edge it latches the winner's a/b/m into the operand registers, records the owner, and goes to START.
  - With both requests high, the winner is the requester that was not served last. `last_owner` resets to 1, so `req0` wins the first tie.
- **START** (exactly 1 cycle):
  - `mult_resetn`=1, `mult_start`=1, `ack<owner>`=1; then go to WAIT.
- **WAIT**:
  - `mult_resetn`=1, `mult_start`=0.
  - On the first cycle with `mult_done`=1, capture `mult_result` into `result`, set `last_owner` to the owner, and go to RESP.
- **RESP** (exactly 1 cycle):
  - `done<owner>`=1; `mult_resetn`=0; then go to IDLE.
- `mult_done` is ignored outside WAIT.
- `mult_a`/`mult_b`/`mult_m` always present the operand registers. Nothing is muxed combinationally from the requester inputs.
- A request dropped before its ack is withdrawn with no response. A request that stays high after its done is a new request.
- Only one ack and one done can be high in any cycle; they are never high in the same cycle.

## Timing

- Reset values:
  - All 1-bit outputs 0: ack, done, `err`, `mult_start`, `mult_resetn`.
  - `result`=0, operand registers 0, state IDLE, `last_owner`=1.
- Reset mid-operation aborts with no done pulse. The multiplier returns to reset on the next cycle.
- Latency, taking the accepting edge as k:
  - Request sampled high in IDLE at edge k: START and ack during cycle k+1; WAIT from k+2.
  - `mult_done` high in WAIT cycle d: RESP (done) in d+1, IDLE in d+2.
- Back-to-back: with `req1` pending, its operation is accepted at the edge leaving RESP+1 (first IDLE cycle), so its ack comes 2 cycles after `done0`.
- A request arriving during START, WAIT or RESP waits; it is not queued beyond its level.

## Configuration

`MONT_ARB_TIMEOUT_EN`:
- Defined:
  - A counter in WAIT, cleared on entry to WAIT, increments every WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no `mult_done`, go to RESP: pulse `done<owner>` with `err`=1, and set `result` to 0.
  - `last_owner` updates as normal.
- Undefined: no counter; `err` is tied 0; WAIT lasts until `mult_done`.

## Test plan

The bench uses a behavioural multiplier model with done 20 cycles after start, result = a*b mod m.
1. Single request: `req0` with a=3, b=5, m=7. Required: `ack0` 1 cycle after the request is seen; `mult_start` 1 cycle; `done0` 1 cycle after `mult_done`; `result`=1; `mult_resetn` low again in IDLE.
2. Simultaneous requests just after reset: `req0` (a=2, b=3, m=11) and `req1` (a=4, b=4, m=11). Required: requester 0 served first (`result`=6), then requester 1 (`result`=5); `ack1` 2 cycles after `done0`.
3. Fairness: both requests held high for 4 operations. Required: owners alternate 0,1,0,1.
4. Withdrawal and reset: `req1` asserted then dropped while requester 0 is in WAIT, so there is no `ack1`/`done1`. Then `reset` asserted mid-WAIT: no done, every output at its reset value next cycle.
5. With `MONT_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, model never raises done. Required: `done0` and `err` high together, `result`=0. Without the macro, the arbiter stays in WAIT and `err` stays 0.
